// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fwd_hazard_unit - ID-stage forwarding select, stall and trap control   |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module fwd_hazard_unit #(
  parameter int NSTAGE    = 3,
  parameter int AW        = 5,
  parameter int BEW       = 4,
  parameter int TRAP_HOLD = 1,
  localparam int SW       = $clog2(NSTAGE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rs_rd,
  input  logic                  i_rt_rd,
  input  logic [AW-1:0]         i_rs_addr,
  input  logic [AW-1:0]         i_rt_addr,
  input  logic [NSTAGE*AW-1:0]  i_st_waddr,
  input  logic [NSTAGE*BEW-1:0] i_st_wen,
  input  logic [NSTAGE-1:0]     i_st_load,
  input  logic                  i_lop_req,
  input  logic                  i_lop_busy,
  input  logic                  i_lop_issue,
  input  logic [AW-1:0]         i_lop_waddr,
  input  logic                  i_lop_done,
  input  logic [AW-1:0]         i_lop_done_addr,
  input  logic                  i_trap_in,
  input  logic                  i_cnt_clr,
  output logic [SW-1:0]         o_rs_src,
  output logic [SW-1:0]         o_rt_src,
  output logic                  o_stall,
  output logic                  o_pc_we,
  output logic                  o_ir_we,
  output logic                  o_trap_out,
  output logic [31:0]           o_stall_cnt
);

  localparam int HW = (TRAP_HOLD > 1) ? $clog2(TRAP_HOLD + 1) : 1;

  logic [NSTAGE-1:0] w_rs_match;
  logic [NSTAGE-1:0] w_rt_match;
  logic [SW-1:0]     w_rs_src;
  logic [SW-1:0]     w_rt_src;
  logic              w_rs_load;
  logic              w_rt_load;
  logic              w_sb_haz;
  logic              w_stall;
  logic              w_trap_out;

  logic [2**AW-1:0]  r_pend;
  logic [HW-1:0]     r_hold;
  logic [31:0]       r_stall_cnt;

  for (genvar i = 0; i < NSTAGE; i++) begin : g_match
    assign w_rs_match[i] = i_rs_rd & (i_rs_addr != '0) &
                           (i_st_waddr[i*AW +: AW] == i_rs_addr) & (|i_st_wen[i*BEW +: BEW]);
    assign w_rt_match[i] = i_rt_rd & (i_rt_addr != '0) &
                           (i_st_waddr[i*AW +: AW] == i_rt_addr) & (|i_st_wen[i*BEW +: BEW]);
  end

  // Scan oldest to youngest so the youngest match overrides; only its load flag counts.
  always_comb begin
    w_rs_src  = '0;
    w_rt_src  = '0;
    w_rs_load = 1'b0;
    w_rt_load = 1'b0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      if (w_rs_match[i]) begin
        w_rs_src  = SW'(i + 1);
        w_rs_load = i_st_load[i];
      end
      if (w_rt_match[i]) begin
        w_rt_src  = SW'(i + 1);
        w_rt_load = i_st_load[i];
      end
    end
  end

  assign w_sb_haz   = (i_rs_rd & r_pend[i_rs_addr]) | (i_rt_rd & r_pend[i_rt_addr]);
  assign w_stall    = w_rs_load | w_rt_load | w_sb_haz | (i_lop_req & i_lop_busy);
  assign w_trap_out = i_trap_in & (r_hold == '0) & ~rst;

  // The issue write comes last so it wins over a same-cycle completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      if (i_lop_done)
        r_pend[i_lop_done_addr] <= 1'b0;
      if (i_lop_issue && (i_lop_waddr != '0))
        r_pend[i_lop_waddr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_hold <= '0;
    else if (w_trap_out)
      r_hold <= HW'(TRAP_HOLD);
    else if (r_hold != '0)
      r_hold <= r_hold - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || i_cnt_clr)
      r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign o_rs_src    = w_rs_src;
  assign o_rt_src    = w_rt_src;
  assign o_stall     = w_stall;
  assign o_pc_we     = ~w_stall;
  assign o_ir_we     = ~(w_stall | w_trap_out);
  assign o_trap_out  = w_trap_out;
  assign o_stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding-select and hazard/stall controller for the in-order MIPS pipeline, sitting beside the ID stage. It compares ID-stage source registers against the write addresses of NSTAGE downstream stages and picks the youngest forwarding source. It stalls on load-use and on reads of registers still owed by multi-cycle units, tracked in a per-register scoreboard. It also throttles trap requests to single pulses with a programmable hold-off and counts stall cycles.

## Interface
- NSTAGE, 3: downstream stages with forwarding paths; index 0 = EXE (youngest), NSTAGE-1 = oldest (WB).
- AW, 5: register address width; scoreboard depth is 2**AW.
- BEW, 4: per-stage byte write-enable width.
- TRAP_HOLD, 1: cycles `trap_out` is masked after a trap pulse; must be ≥1.
- SW (derived) = $clog2(NSTAGE+1).
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- rs_rd, rt_rd  in  1  ID instruction reads rs / rt.
- rs_addr, rt_addr  in  AW  ID source register addresses.
- st_waddr  in  NSTAGE*AW  per-stage destination; slice i = [i*AW +: AW].
- st_wen  in  NSTAGE*BEW  per-stage byte write enables.
- st_load  in  NSTAGE  stage i result not yet available (load in flight).
- lop_req  in  1  ID instruction needs the long-latency unit.
- lop_busy  in  1  long-latency unit occupied.
- lop_issue  in  1  long-latency op accepted this cycle, destination `lop_waddr`.
- lop_waddr  in  AW  destination of the issuing long op.
- lop_done  in  1  long op result written this cycle, destination `lop_done_addr`.
- lop_done_addr  in  AW  destination being completed.
- trap_in  in  1  raw trap request from decode.
- cnt_clr  in  1  clear stall counter.
- rs_src, rt_src  out  SW  0 = register file; k = stage k-1.
- stall  out  1  hold ID and IF.
- pc_we  out  1  = ~stall.
- ir_we  out  1  = ~(stall | trap_out).
- trap_out  out  1  qualified trap pulse.
- stall_cnt  out  32  saturating count of stalled cycles.

## Operation
- match_x[i] = x_rd & (x_addr≠0) & (st_waddr[i]==x_addr) & |st_wen[i], for x ∈ {rs, rt}.
- x_src = i+1 for the lowest i with match_x[i]; 0 if none. The youngest stage always wins.
- load_haz_x = st_load[i] of the selected stage only. An older matching load, shadowed by a younger match, does not stall.
- Scoreboard `pend[2**AW]`, all registered:
  - lop_issue with lop_waddr≠0 sets the bit.
  - lop_done clears the bit at lop_done_addr.
  - Issue and done on the same address in one cycle: the set wins.
  - Bit 0 is never set.
- sb_haz_x = x_rd & pend[x_addr], using the registered value. A clear by lop_done is seen from the next cycle.
- stall = load_haz_rs | load_haz_rt | sb_haz_rs | sb_haz_rt | (lop_req & lop_busy).
- Trap hold counter `hold`:
  - trap_out = trap_in & (hold==0) & ~rst.
  - On trap_out, hold ← TRAP_HOLD; otherwise it decrements while >0.
  - TRAP_HOLD=1 gives the legacy one-cycle mask: a held trap_in pulses on alternate cycles.
- stall_cnt: on rst or cnt_clr → 0. Otherwise it increments when stall=1 and saturates at 0xFFFFFFFF. cnt_clr has priority over increment.

## Timing
- src, stall, pc_we, ir_we and trap_out are combinational from inputs and registered state. There is no added latency.
- Scoreboard update: one cycle after lop_issue/lop_done. A read of lop_waddr in the cycle after issue stalls.
- Reset values:
  - Registers: pend = 0, hold = 0, stall_cnt = 0.
  - During rst: trap_out = 0.
  - With idle inputs: src = 0, stall = 0, pc_we = 1, ir_we = 1.
- Reset mid-operation clears all pending bits. Any late lop_done then has no effect.
- stall_cnt updates on the edge ending each stalled cycle.

## Test plan
- Priority: rs_addr=8, stage0 and stage2 both write r8 (wen=4'hF), no loads → rs_src=1, stall=0. Drop stage0 wen → rs_src=3.
- Load-use: stage0 writes r9 with st_load[0]=1, rt_addr=9, rt_rd=1 → stall=1, pc_we=0, ir_we=0. Clear st_load → stall=0, rt_src=1.
- Scoreboard: lop_issue r12 at cycle 0; read r12 at cycles 1-5 → stall=1. lop_done r12 at cycle 5 → stall=0 at cycle 6. Simultaneous issue+done r12 → bit stays set.
- Zero register: rs_addr=0 matching stage0 writing r0, and lop_issue r0 → rs_src=0, stall=0 throughout.
- Trap with TRAP_HOLD=3: trap_in held high 8 cycles → trap_out=1 at cycles 0 and 4 only. ir_we=0 on those cycles.
- Counter: 5 stalled cycles → stall_cnt=5. cnt_clr during a stall → 0 next cycle. Preload near max → saturates at 0xFFFFFFFF.
